fb_scanout: RTL and testbench

Video scan-out stage that sits directly downstream of the frame-buffer RAM (15-bit RGB555 words, one-cycle registered read). It generates raster timing, drives the RAM read address for the frame-buffer window with integer pixel replication, absorbs the RAM's one-cycle read latency, and presents aligned sync, data-enable and pixel outputs to the display encoder.

---
 rtl/fb_scanout.sv | 177 +++++++++++++++++
 tb/tb_fb_scanout.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/fb_scanout.sv
// Frame-buffer scan-out: raster timing, replicated-pixel RAM addressing and a
// two-stage output pipeline that aligns sync/de/pixel with the RAM read latency.
module fb_scanout #(
    parameter int RAM_DATA_WIDTH = 15,
    parameter int RAM_ADDR_WIDTH = 16,
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int FB_WIDTH  = 240,
    parameter int FB_HEIGHT = 160,
    parameter int SCALE     = 2,
    parameter logic [RAM_DATA_WIDTH-1:0] BORDER_COLOR = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic [RAM_ADDR_WIDTH-1:0] read_addr,
    input  logic [RAM_DATA_WIDTH-1:0] ram_q,
    output logic                      hsync,
    output logic                      vsync,
    output logic                      de,
    output logic [RAM_DATA_WIDTH-1:0] pixel,
    output logic                      frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam int SW = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam int AW = RAM_ADDR_WIDTH;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_WIN  = HW'(FB_WIDTH * SCALE);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_WIN  = VW'(FB_HEIGHT * SCALE);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [SW-1:0] S_LAST = SW'(SCALE - 1);
    localparam logic [AW-1:0] FBW    = AW'(FB_WIDTH);

    if (SCALE < 1) begin : g_err_scale
        $error("fb_scanout: SCALE must be >= 1");
    end
    if (FB_WIDTH * SCALE > H_ACTIVE) begin : g_err_w
        $error("fb_scanout: scaled FB_WIDTH exceeds H_ACTIVE");
    end
    if (FB_HEIGHT * SCALE > V_ACTIVE) begin : g_err_h
        $error("fb_scanout: scaled FB_HEIGHT exceeds V_ACTIVE");
    end
    if (longint'(FB_WIDTH) * FB_HEIGHT > (longint'(1) << RAM_ADDR_WIDTH)) begin : g_err_a
        $error("fb_scanout: frame buffer does not fit RAM_ADDR_WIDTH");
    end

    typedef struct packed {
        logic win;
        logic act;
        logic hs_n;
        logic vs_n;
        logic fs;
    } flags_t;

    localparam flags_t FLAGS_RST = '{win: 1'b0, act: 1'b0, hs_n: 1'b1, vs_n: 1'b1, fs: 1'b0};

    logic [HW-1:0] h_cnt, h_nxt;
    logic [VW-1:0] v_cnt, v_nxt;
    logic [AW-1:0] fb_x, fb_x_nxt, line_base, lb_nxt, addr_nxt;
    logic [SW-1:0] sx, sx_nxt, sy, sy_nxt;
    logic          in_win, win_nxt;
    flags_t        cur, s1;

    // Next raster position and the address state that goes with it; read_addr
    // is registered alongside the counters so both describe the same pixel.
    always_comb begin
        h_nxt    = h_cnt;
        v_nxt    = v_cnt;
        fb_x_nxt = fb_x;
        sx_nxt   = sx;
        lb_nxt   = line_base;
        sy_nxt   = sy;
        in_win   = (h_cnt < H_WIN) && (v_cnt < V_WIN);
        if (h_cnt == H_LAST) begin
            h_nxt    = '0;
            fb_x_nxt = '0;
            sx_nxt   = '0;
            if (v_cnt == V_LAST) begin
                v_nxt  = '0;
                lb_nxt = '0;
                sy_nxt = '0;
            end else begin
                v_nxt = v_cnt + VW'(1);
                if (v_cnt < V_WIN) begin
                    if (sy == S_LAST) begin
                        sy_nxt = '0;
                        lb_nxt = line_base + FBW;
                    end else begin
                        sy_nxt = sy + SW'(1);
                    end
                end
            end
        end else begin
            h_nxt = h_cnt + HW'(1);
            if (in_win) begin
                if (sx == S_LAST) begin
                    sx_nxt   = '0;
                    fb_x_nxt = fb_x + AW'(1);
                end else begin
                    sx_nxt = sx + SW'(1);
                end
            end
        end
        win_nxt  = (h_nxt < H_WIN) && (v_nxt < V_WIN);
        addr_nxt = win_nxt ? (lb_nxt + fb_x_nxt) : read_addr;
    end

    always_comb begin
        cur      = FLAGS_RST;
        cur.win  = in_win;
        cur.act  = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        cur.hs_n = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
        cur.vs_n = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
        cur.fs   = (h_cnt == '0) && (v_cnt == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt     <= '0;
            v_cnt     <= '0;
            fb_x      <= '0;
            sx        <= '0;
            line_base <= '0;
            sy        <= '0;
            read_addr <= '0;
        end else begin
            h_cnt     <= h_nxt;
            v_cnt     <= v_nxt;
            fb_x      <= fb_x_nxt;
            sx        <= sx_nxt;
            line_base <= lb_nxt;
            sy        <= sy_nxt;
            read_addr <= addr_nxt;
        end
    end

    // Stage 1 waits out the RAM read; stage 2 registers the display outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1          <= FLAGS_RST;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            de          <= 1'b0;
            pixel       <= '0;
            frame_start <= 1'b0;
        end else begin
            s1          <= cur;
            hsync       <= s1.hs_n;
            vsync       <= s1.vs_n;
            de          <= s1.act;
            frame_start <= s1.fs;
            if (s1.win)
                pixel <= ram_q;
            else if (s1.act)
                pixel <= BORDER_COLOR;
            else
                pixel <= '0;
        end
    end

endmodule

// File: tb/tb_fb_scanout.sv
// Random-reset bench for fb_scanout: three scale configurations on one small
// raster, each compared cycle by cycle with a pixel-index reference model.
module tb_fb_scanout;

    localparam int HA = 40, HFP = 4, HSY = 6, HBP = 6;
    localparam int VA = 20, VFP = 2, VSY = 2, VBP = 3;
    localparam int HT = HA + HFP + HSY + HBP;
    localparam int VT = VA + VFP + VSY + VBP;
    localparam int FT = HT * VT;
    localparam int AW = 10;
    localparam int DW = 15;
    localparam int N  = 3;

    function automatic int fw(int i);
        return (i == 0) ? 16 : (i == 1) ? 40 : 12;
    endfunction
    function automatic int fh(int i);
        return (i == 0) ? 8 : (i == 1) ? 20 : 6;
    endfunction
    function automatic int sc(int i);
        return (i == 0) ? 2 : (i == 1) ? 1 : 3;
    endfunction
    function automatic logic [DW-1:0] bc(int i);
        return (i == 0) ? 15'h1234 : (i == 1) ? 15'h7fff : 15'h0000;
    endfunction

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [DW-1:0] mem [1 << AW];
    logic [AW-1:0] ra [N];
    logic [DW-1:0] rq [N];
    logic [DW-1:0] px [N];
    logic [N-1:0]  hs, vs, de, fs;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        fb_scanout #(
            .RAM_DATA_WIDTH(DW), .RAM_ADDR_WIDTH(AW),
            .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
            .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
            .FB_WIDTH(fw(g)), .FB_HEIGHT(fh(g)), .SCALE(sc(g)),
            .BORDER_COLOR(bc(g))
        ) u_dut (
            .clk(clk), .reset(reset), .read_addr(ra[g]), .ram_q(rq[g]),
            .hsync(hs[g]), .vsync(vs[g]), .de(de[g]), .pixel(px[g]),
            .frame_start(fs[g])
        );
    end

    // Registered-read frame-buffer RAM, one copy of the contents shared by all DUTs.
    always @(posedge clk)
        for (int i = 0; i < N; i++) rq[i] <= mem[ra[i]];

    int total = 0;
    int bad   = 0;
    int k [N];
    int last_addr [N];
    int max_addr [N];
    int n_fs [N], n_de [N], n_vs [N], n_hs [N];
    bit agg_on = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    task automatic check_inst(input int i);
        int h, v, p, ph, pv, w, s;
        logic ehs, evs, ede, efs;
        logic [DW-1:0] epx;
        w = fw(i); s = sc(i);
        h = k[i] % HT;
        v = (k[i] / HT) % VT;
        if (h < w * s && v < fh(i) * s) last_addr[i] = (v / s) * w + h / s;
        chk($sformatf("u%0d k%0d read_addr", i, k[i]), 32'(ra[i]), 32'(last_addr[i]));
        if (32'(ra[i]) > max_addr[i] && !$isunknown(ra[i])) max_addr[i] = int'(ra[i]);
        ehs = 1'b1; evs = 1'b1; ede = 1'b0; efs = 1'b0; epx = '0;
        if (k[i] >= 2) begin
            p   = k[i] - 2;
            ph  = p % HT;
            pv  = (p / HT) % VT;
            ehs = !(ph >= HA + HFP && ph < HA + HFP + HSY);
            evs = !(pv >= VA + VFP && pv < VA + VFP + VSY);
            ede = (ph < HA) && (pv < VA);
            efs = (p % FT) == 0;
            if (ph < w * s && pv < fh(i) * s) epx = mem[(pv / s) * w + ph / s];
            else if (ede) epx = bc(i);
        end
        chk($sformatf("u%0d k%0d hsync", i, k[i]), 32'(hs[i]), 32'(ehs));
        chk($sformatf("u%0d k%0d vsync", i, k[i]), 32'(vs[i]), 32'(evs));
        chk($sformatf("u%0d k%0d de", i, k[i]), 32'(de[i]), 32'(ede));
        chk($sformatf("u%0d k%0d pixel", i, k[i]), 32'(px[i]), 32'(epx));
        chk($sformatf("u%0d k%0d frame_start", i, k[i]), 32'(fs[i]), 32'(efs));
        if (agg_on && k[i] >= 2 && k[i] < 2 + FT) begin
            n_fs[i] += int'(fs[i]);
            n_de[i] += int'(de[i]);
            n_vs[i] += int'(!vs[i]);
            n_hs[i] += int'(!hs[i]);
        end
    endtask

    task automatic cycle(input logic r);
        reset = r;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (r) begin
                k[i] = 0;
                last_addr[i] = 0;
            end else begin
                k[i]++;
            end
            check_inst(i);
        end
    endtask

    initial begin
        for (int a = 0; a < (1 << AW); a++) mem[a] = DW'($urandom);
        for (int i = 0; i < N; i++) begin
            k[i] = 0; last_addr[i] = 0; max_addr[i] = 0;
            n_fs[i] = 0; n_de[i] = 0; n_vs[i] = 0; n_hs[i] = 0;
        end

        // Clean start and two uninterrupted frames for the per-frame totals.
        repeat (3) cycle(1'b1);
        agg_on = 1;
        repeat (2 * FT + 10) cycle(1'b0);
        agg_on = 0;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("u%0d frame_start/frame", i), 32'(n_fs[i]), 32'd1);
            chk($sformatf("u%0d de cycles/frame", i), 32'(n_de[i]), 32'(HA * VA));
            chk($sformatf("u%0d vsync low/frame", i), 32'(n_vs[i]), 32'(VSY * HT));
            chk($sformatf("u%0d hsync low/frame", i), 32'(n_hs[i]), 32'(HSY * VT));
            chk($sformatf("u%0d max read_addr", i), 32'(max_addr[i]), 32'(fw(i) * fh(i) - 1));
        end

        // Resets dropped at random raster positions, including mid-line.
        for (int it = 0; it < 16; it++) begin
            repeat ($urandom_range(1, 1800)) cycle(1'b0);
            repeat ($urandom_range(1, 4)) cycle(1'b1);
        end
        repeat (FT + 5) cycle(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
